// File: rtl/node_port_tx.sv
// node_port_tx: link transmit port with a registered output stage backed by a skid FIFO
module node_port_tx #(
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [FLIT_WIDTH-1:0]         in_flit,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [FLIT_WIDTH-1:0]         port_flit,
    output logic                          port_enable,
    input  logic                          port_ack,
    output logic [$clog2(DEPTH+2)-1:0]    occupancy,
    output logic [15:0]                   stall_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+2);

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic                  live;
    logic                  accept, xfer, fifo_empty, fifo_rd, fifo_wr;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake decode; the FIFO count is the total minus the output register.
    always_comb begin
        fifo_empty = occupancy == OW'(port_enable);
        in_ready   = live && (occupancy < OW'(DEPTH+1));
        accept     = in_valid && in_ready;
        xfer       = port_enable && port_ack;
        fifo_rd    = xfer && !fifo_empty;
        fifo_wr    = accept && port_enable && !(xfer && fifo_empty);
    end

    // Output register, pointers, occupancy and stall counter; live gates in_ready until the first edge out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live        <= 1'b0;
            port_enable <= 1'b0;
            port_flit   <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occupancy   <= '0;
            stall_cnt   <= '0;
        end else begin
            live <= 1'b1;
            if (fifo_rd) rd_ptr <= inc(rd_ptr);
            if (fifo_wr) wr_ptr <= inc(wr_ptr);
            if (xfer) begin
                port_enable <= !fifo_empty || accept;
                port_flit   <= !fifo_empty ? mem[rd_ptr] : (accept ? in_flit : '0);
            end else if (accept && !port_enable) begin
                port_enable <= 1'b1;
                port_flit   <= in_flit;
            end
            if (accept && !xfer) occupancy <= occupancy + 1'b1;
            else if (xfer && !accept) occupancy <= occupancy - 1'b1;
            if (port_enable && !port_ack && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // FIFO storage carries no reset; pointers and occupancy define which entries are live.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr] <= in_flit;
    end
endmodule

// File: tb/tb_node_port_tx.sv
// tb_node_port_tx: directed and reference-queue checks for node_port_tx
module tb_node_port_tx;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] port_flit;
    logic        port_enable;
    logic        port_ack;
    logic [2:0]  occupancy;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    node_port_tx #(.FLIT_WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_valid(in_valid),
        .in_ready(in_ready), .port_flit(port_flit), .port_enable(port_enable),
        .port_ack(port_ack), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_en", port_enable, 0);
        check("rst_occ", occupancy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ready", in_ready, 1);
    endtask

    initial begin
        int acc;
        int n;
        logic [31:0] q[$];
        logic [31:0] held;
        bit hold;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_flit = '0;
        port_ack = 1'b0;
        #2;
        check("reset_en", port_enable, 0);
        check("reset_flit", port_flit, 0);
        check("reset_occ", occupancy, 0);
        check("reset_stall", stall_cnt, 0);
        check("reset_ready", in_ready, 0);
        tick();
        check("reset_ready_held", in_ready, 0);
        rst_n = 1'b1;
        tick();
        check("ready_after_reset", in_ready, 1);
        check("en_after_reset", port_enable, 0);

        // single flit
        in_flit = 32'hA5A5A5A5;
        in_valid = 1'b1;
        port_ack = 1'b1;
        tick();
        in_valid = 1'b0;
        check("single_en", port_enable, 1);
        check("single_flit", port_flit, 32'hA5A5A5A5);
        check("single_occ", occupancy, 1);
        tick();
        check("single_en_off", port_enable, 0);
        check("single_occ0", occupancy, 0);
        check("single_flit0", port_flit, 0);

        // fill under backpressure
        port_ack = 1'b0;
        acc = 0;
        for (int i = 1; i <= 6; i++) begin
            in_flit = i;
            in_valid = 1'b1;
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        check("fill_accepted", acc, 5);
        check("fill_ready", in_ready, 0);
        check("fill_occ", occupancy, 5);
        check("fill_flit", port_flit, 1);
        check("fill_stall", stall_cnt, 5);

        // drain in order
        port_ack = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            check("drain_en", port_enable, 1);
            check("drain_flit", port_flit, k);
            tick();
            if (k == 1) check("drain_ready", in_ready, 1);
        end
        check("drain_done_en", port_enable, 0);
        check("drain_done_occ", occupancy, 0);
        check("drain_stall", stall_cnt, 5);

        // streaming
        do_reset();
        check("stream_stall0", stall_cnt, 0);
        in_valid = 1'b1;
        port_ack = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_flit = 100 + i;
            tick();
            check("stream_flit", port_flit, 100 + i);
            check("stream_occ", occupancy, 1);
            check("stream_en", port_enable, 1);
        end
        in_valid = 1'b0;
        tick();
        check("stream_end_occ", occupancy, 0);
        check("stream_stall", stall_cnt, 0);

        // saturation then mid-cycle reset
        in_flit = 32'hDEADBEEF;
        in_valid = 1'b1;
        port_ack = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (70000) tick();
        check("sat_stall", stall_cnt, 16'hFFFF);
        check("sat_flit", port_flit, 32'hDEADBEEF);
        check("sat_en", port_enable, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_en", port_enable, 0);
        check("async_stall", stall_cnt, 0);
        check("async_flit", port_flit, 0);
        check("async_occ", occupancy, 0);
        check("async_ready", in_ready, 0);
        tick();
        check("in_reset_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        check("post_reset_ready", in_ready, 1);
        check("post_reset_en", port_enable, 0);

        // random backpressure against a reference queue
        hold = 1'b0;
        held = '0;
        for (int c = 0; c < 10000; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_flit = $urandom;
            port_ack = 1'($urandom_range(0, 1));
            check("rnd_occ", occupancy, q.size());
            check("rnd_en", port_enable, q.size() != 0);
            if (hold) begin
                check("rnd_hold_en", port_enable, 1);
                check("rnd_hold_flit", port_flit, held);
            end
            hold = port_enable && !port_ack;
            held = port_flit;
            if (port_enable && port_ack && q.size() != 0) check("rnd_data", port_flit, q.pop_front());
            if (in_valid && in_ready) q.push_back(in_flit);
            tick();
        end
        in_valid = 1'b0;
        port_ack = 1'b1;
        n = 0;
        while (port_enable && n < 20) begin
            if (q.size() != 0) check("rnd_drain", port_flit, q.pop_front());
            tick();
            n++;
        end
        check("rnd_queue_empty", q.size(), 0);
        check("rnd_final_occ", occupancy, 0);
        check("rnd_final_en", port_enable, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
